button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/btn_cond_pkg.sv | 24 ++
 rtl/debounce_channel.sv | 125 ++++++++++++
 rtl/button_conditioner.sv | 63 ++++++
 tb/tb_button_conditioner.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/btn_cond_pkg.sv
// Shared types and default timing for the push-button conditioner.
// Cycle-count defaults assume a 50 MHz system clock.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES     = 500_000;
  localparam int DEFAULT_REPEAT_DELAY_CYCLES = 25_000_000;
  localparam int DEFAULT_REPEAT_RATE_CYCLES  = 5_000_000;

  // A counter that must hold 0..n-1 needs $clog2(n) bits, but never fewer than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: 2-flop synchronizer, stable-sample debouncer and press FSM.
// Auto-repeat (HELD delay and REPEAT rate counters) exists only when BTN_AUTO_REPEAT_EN is defined.
module debounce_channel
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEFAULT_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEFAULT_REPEAT_RATE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic pulse
);

  localparam int              DB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            level_q, level_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;

  btn_state_e state_q;
  logic       pulse_q;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int               RPT_W      = cnt_width(max_int(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES));
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);

  logic [RPT_W-1:0] rpt_cnt_q;
`endif

  // The level only flips after DEBOUNCE_CYCLES consecutive samples that disagree with it;
  // any agreeing sample restarts the count.
  always_comb begin
    sync1_d  = key_n;
    sync2_d  = sync1_q;
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      level_q  <= 1'b1;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Debounced release wins over any pending repeat pulse in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pulse_q <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rpt_cnt_q <= '0;
`endif
    end else begin
      pulse_q <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rpt_cnt_q <= rpt_cnt_q + RPT_ONE;
`endif
      case (state_q)
        ST_IDLE: begin
`ifdef BTN_AUTO_REPEAT_EN
          rpt_cnt_q <= '0;
`endif
          if (!level_q) begin
            state_q <= ST_HELD;
            pulse_q <= 1'b1;
          end
        end
        ST_HELD: begin
          if (level_q) begin
            state_q <= ST_IDLE;
`ifdef BTN_AUTO_REPEAT_EN
            rpt_cnt_q <= '0;
          end else if (rpt_cnt_q == DELAY_LAST) begin
            state_q   <= ST_REPEAT;
            pulse_q   <= 1'b1;
            rpt_cnt_q <= '0;
`endif
          end
        end
`ifdef BTN_AUTO_REPEAT_EN
        ST_REPEAT: begin
          if (level_q) begin
            state_q   <= ST_IDLE;
            rpt_cnt_q <= '0;
          end else if (rpt_cnt_q == RATE_LAST) begin
            pulse_q   <= 1'b1;
            rpt_cnt_q <= '0;
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
`ifdef BTN_AUTO_REPEAT_EN
          rpt_cnt_q <= '0;
`endif
        end
      endcase
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Up/down push-button conditioner: two debounced channels plus mutually exclusive registered pulses.
// Define BTN_AUTO_REPEAT_EN to enable hold-to-repeat pulses.
module button_conditioner
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEFAULT_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEFAULT_REPEAT_RATE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_up_n,
  input  logic key_down_n,
  output logic btn_up,
  output logic btn_down
);

  logic req_up, req_down;
  logic btn_up_q, btn_up_d;
  logic btn_down_q, btn_down_d;

  debounce_channel #(
    .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
    .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES)
  ) u_up (
    .clk    (clk),
    .reset_n(reset_n),
    .key_n  (key_up_n),
    .pulse  (req_up)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
    .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES)
  ) u_down (
    .clk    (clk),
    .reset_n(reset_n),
    .key_n  (key_down_n),
    .pulse  (req_down)
  );

  // Simultaneous requests are ambiguous for the value register, so both are dropped.
  always_comb begin
    btn_up_d   = req_up & ~req_down;
    btn_down_d = req_down & ~req_up;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      btn_up_q   <= 1'b0;
      btn_down_q <= 1'b0;
    end else begin
      btn_up_q   <= btn_up_d;
      btn_down_q <= btn_down_d;
    end
  end

  assign btn_up   = btn_up_q;
  assign btn_down = btn_down_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE=4, DELAY=10, RATE=3.
// Expected pulses are queued by the stimulus; a negedge monitor pops and compares them.
module tb_button_conditioner;

  localparam int DB   = 4;
  localparam int DLY  = 10;
  localparam int RATE = 3;

  typedef struct {
    int unsigned cyc;
    logic        isUp;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic key_up_n;
  logic key_down_n;
  logic btn_up;
  logic btn_down;

  exp_t        expQ[$];
  int unsigned cycleCount = 0;
  int          checks     = 0;
  int          failures   = 0;
  bit          monitorEn  = 1'b0;

  button_conditioner #(
    .DEBOUNCE_CYCLES    (DB),
    .REPEAT_DELAY_CYCLES(DLY),
    .REPEAT_RATE_CYCLES (RATE)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_up_n  (key_up_n),
    .key_down_n(key_down_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down)
  );

  always #5 clk = ~clk;

  // Edge index: after the n-th rising edge, cycleCount == n.
  always @(posedge clk) cycleCount++;

  // Monitor: exclusivity every cycle, and every presented pulse is matched against the queue head.
  always @(negedge clk) begin
    if (monitorEn) begin
      checks++;
      if (btn_up && btn_down) begin
        failures++;
        $display("[TB] FAIL exclusive: btn_up=%0b btn_down=%0b at cycle %0d, required never both 1",
                 btn_up, btn_down, cycleCount);
      end
      if (btn_up || btn_down) begin
        exp_t e;
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_pulse: up=%0b down=%0b at cycle %0d, required no pulse",
                   btn_up, btn_down, cycleCount);
        end else begin
          e = expQ.pop_front();
          if (e.cyc != cycleCount || e.isUp != btn_up) begin
            failures++;
            $display("[TB] FAIL pulse_match: got up=%0b at cycle %0d, required up=%0b at cycle %0d",
                     btn_up, cycleCount, e.isUp, e.cyc);
          end
        end
      end
    end
  end

  task automatic pushExpected(input int unsigned cyc, input logic isUp);
    exp_t e;
    e.cyc  = cyc;
    e.isUp = isUp;
    expQ.push_back(e);
  endtask

  // Called at a negedge: drive keys now, then hold them for holdCycles clocks.
  task automatic applyStimulus(input logic upN, input logic downN, input int holdCycles);
    key_up_n   = upN;
    key_down_n = downN;
    repeat (holdCycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic expUp, input logic expDown);
    checks++;
    if (btn_up !== expUp || btn_down !== expDown) begin
      failures++;
      $display("[TB] FAIL %s: got up=%0b down=%0b, required up=%0b down=%0b",
               name, btn_up, btn_down, expUp, expDown);
    end
  endtask

  task automatic checkQueueEmpty(input string name);
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s: %0d expected pulses never seen (next at cycle %0d), required 0",
               name, expQ.size(), expQ[0].cyc);
      expQ.delete();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int unsigned base;
    int unsigned rel;

    reset_n    = 1'b0;
    key_up_n   = 1'b1;
    key_down_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", 1'b0, 1'b0);
    reset_n   = 1'b1;
    monitorEn = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] clean press on up");
    base = cycleCount + 1;
    pushExpected(base + 7, 1'b1);
    applyStimulus(1'b0, 1'b1, 8);
    applyStimulus(1'b1, 1'b1, 40);
    checkQueueEmpty("clean_press");

    $display("[TB] 3-clock glitch on down");
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b1, 1'b1, 40);
    checkQueueEmpty("glitch");

    $display("[TB] 40-clock hold on up");
    base = cycleCount + 1;
    pushExpected(base + 7, 1'b1);
`ifdef BTN_AUTO_REPEAT_EN
    pushExpected(base + 17, 1'b1);
    for (int c = 20; c <= 44; c += 3) pushExpected(base + c, 1'b1);
`endif
    applyStimulus(1'b0, 1'b1, 40);
    applyStimulus(1'b1, 1'b1, 40);
    checkQueueEmpty("hold");

    $display("[TB] simultaneous press");
    applyStimulus(1'b0, 1'b0, 8);
    applyStimulus(1'b1, 1'b1, 40);
    checkQueueEmpty("simultaneous");

    $display("[TB] reset during press, key held through release");
    applyStimulus(1'b0, 1'b1, 5);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("reset_mid_press", 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reset_held", 1'b0, 1'b0);
    reset_n = 1'b1;
    rel = cycleCount + 1;
    pushExpected(rel + 7, 1'b1);
    applyStimulus(1'b0, 1'b1, 8);
    applyStimulus(1'b1, 1'b1, 40);
    checkQueueEmpty("reset_release_press");

    $display("[TB] down press after reset");
    base = cycleCount + 1;
    pushExpected(base + 7, 1'b0);
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b1, 1'b1, 40);
    checkQueueEmpty("down_press");

    monitorEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
